photon_history_ring: RTL and testbench
======================================

# photon_history_ring

Parametrised multi-channel photon-count history manager. Keeps a DEPTH-entry history per channel in an SDRAM region and appends each new pulse count. Two modes: legacy physical left-shift (oldest word discarded), or ring mode (single write at a head pointer). Sits between the pulse counters and the SDRAM read/write glue, ahead of the LCD plot renderer that reads the history.

## Interface
- DATA_W, 16, sample/SDRAM word width
- ADDR_W, 24, SDRAM address width (bank+row+column)
- DEPTH, 600, entries per channel (≥2)
- CHANNELS, 2, channel count (1..8); CH_W = max(1,$clog2(CHANNELS)), PTR_W = $clog2(DEPTH)
- BASE_ADDR, 384000, address of channel 0 entry 0
- CH_STRIDE, 1024, address distance between channels (≥DEPTH)

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  permits leaving IDLE
- i_mode  in  1  0 = shift, 1 = ring
- i_sample_valid  in  1  one-cycle strobe, new count
- i_sample_ch  in  CH_W  channel of sample
- i_sample_data  in  DATA_W  pulse count
- o_rd_req / o_rd_addr / i_rd_data / i_rd_done  out 1 / out ADDR_W / in DATA_W / in 1  SDRAM read
- o_wr_req / o_wr_addr / o_wr_data / i_wr_done  out 1 / out ADDR_W / out DATA_W / in 1  SDRAM write
- o_head  out  CHANNELS*PTR_W  per-channel next-write index (ring mode; 0 in shift mode)
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle pulse per completed update
- o_drop_cnt  out  16  saturating count of overwritten pending samples

## Operation
- Per channel one-deep pending slot (flag + data). Valid sample: slot loaded. If flag already set and not being cleared that cycle, data overwritten, o_drop_cnt += 1 (saturates 0xFFFF).
- Same-cycle sample and slot clear by PICK: new sample wins, flag stays set, no drop counted.
- Entry k of channel c at BASE_ADDR + c*CH_STRIDE + k.
- FSM: IDLE → PICK when en && any flag. PICK: round-robin choice starting after last served channel; snapshot data, clear flag, latch i_mode. Shift → RD_REQ (k=1); ring → RING_WR.
- RD_REQ: read entry k; on i_rd_done capture i_rd_data → WR_REQ writing entry k-1 → SHIFT_NEXT: if k==DEPTH-1 → TAIL_WR else k+1 → RD_REQ.
- TAIL_WR: write snapshot to entry DEPTH-1 → FINISH.
- RING_WR: write snapshot to entry head[c]; on done head[c] ← (head==DEPTH-1) ? 0 : head+1 → FINISH.
- FINISH: o_done pulse → IDLE.
- en is sampled only in IDLE; an update in progress always completes.
- Mode change affects only the next PICK; no memory reorganisation, heads not cleared.

## Timing
- Reset: all outputs 0, heads 0, flags clear, FSM IDLE, round-robin pointer at channel 0.
- Handshake: req and address/data registered, held stable until done sampled high; req drops on the edge that samples done. Next req at least one cycle later. Read and write never both asserted.
- Ring latency with done one cycle after req: sample cycle 0, flag cycle 1, PICK cycle 2, o_wr_req cycle 3, done cycle 4, o_done cycle 5, IDLE cycle 6.
- Shift update: (DEPTH-1) × (read + write + 1 SHIFT_NEXT cycle) + tail write + PICK + FINISH.
- Reset mid-operation drops requests immediately; SDRAM controller aborts its own transfer.

## Structure
- Package photon_hist_pkg: state enum (IDLE, PICK, RD_REQ, WR_REQ, SHIFT_NEXT, TAIL_WR, RING_WR, FINISH), mode constants, entry_addr(c,k) function.
- Sub-module photon_hist_pending: pending slots, drop counter, round-robin arbiter.

## Test plan
- Ring, CHANNELS=2, DEPTH=4: samples 10, 11, 12, 13, 14 on ch0 → writes to 384000,1,2,3,0; o_head[0] 1,2,3,0,1; o_done five pulses.
- Shift, DEPTH=4, memory 1,2,3,4, sample 9 → reads 1,2,3 / writes 0,1,2 with 2,3,4, tail 9 at 384003; final 2,3,4,9.
- Overflow: ch1 samples 5 then 6 while ch0 update busy → ch1 writes 6, o_drop_cnt=1.
- Round-robin: ch0 and ch1 pending together, last served ch0 → ch1 serviced first.
- en low with pending → no req, o_busy 0; en high → update starts on next PICK.
- rst asserted during RD_REQ → o_rd_req 0 same cycle, heads 0, flags clear; next sample processes normally.

Source files
------------

// File: rtl/photon_hist_pkg.sv
// rtl/photon_hist_pkg.sv - shared states, mode constants and address helper for the photon history ring
package photon_hist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        RD_REQ,
        WR_REQ,
        SHIFT_NEXT,
        TAIL_WR,
        RING_WR,
        FINISH
    } state_t;

    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_RING  = 1'b1;

    // Entry k of channel ch lives at base + ch*stride + k.
    function automatic logic [31:0] entry_addr(input logic [31:0] base, input logic [31:0] stride,
                                               input logic [31:0] ch, input logic [31:0] k);
        return base + ch * stride + k;
    endfunction

endpackage

// File: rtl/photon_hist_pending.sv
// rtl/photon_hist_pending.sv - per-channel pending slots, drop counter and round-robin pick
module photon_hist_pending #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sampleValid,
    input  logic [CH_W-1:0]   sampleCh,
    input  logic [DATA_W-1:0] sampleData,
    input  logic              pickClr,
    output logic              anyPending,
    output logic [CH_W-1:0]   pickCh,
    output logic [DATA_W-1:0] pickData,
    output logic [15:0]       dropCnt
);

    logic [CHANNELS-1:0] flags;
    logic [DATA_W-1:0]   slotData [CHANNELS];
    logic [CH_W-1:0]     lastCh;
    logic [CH_W-1:0]     idx;
    logic                found;

    // Round-robin search starting at the channel after the one served last.
    always_comb begin
        pickCh = lastCh;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = CH_W'((int'(lastCh) + i) % CHANNELS);
            if (!found && flags[idx]) begin
                found  = 1'b1;
                pickCh = idx;
            end
        end
    end

    assign anyPending = |flags;
    assign pickData   = slotData[pickCh];

    // Slot load/clear; a sample arriving with a PICK clear on the same channel keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags   <= '0;
            lastCh  <= '0;
            dropCnt <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                slotData[c] <= '0;
            end
        end else begin
            if (pickClr) begin
                flags[pickCh] <= 1'b0;
                lastCh        <= pickCh;
            end
            if (sampleValid) begin
                flags[sampleCh]    <= 1'b1;
                slotData[sampleCh] <= sampleData;
                if (flags[sampleCh] && !(pickClr && pickCh == sampleCh) && dropCnt != 16'hFFFF) begin
                    dropCnt <= dropCnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/photon_history_ring.sv
// rtl/photon_history_ring.sv - per-channel photon-count history in SDRAM, shift or ring append
module photon_history_ring
    import photon_hist_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 24,
    parameter int DEPTH     = 600,
    parameter int CHANNELS  = 2,
    parameter int BASE_ADDR = 384000,
    parameter int CH_STRIDE = 1024,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      i_mode,
    input  logic                      i_sample_valid,
    input  logic [CH_W-1:0]           i_sample_ch,
    input  logic [DATA_W-1:0]         i_sample_data,
    output logic                      o_rd_req,
    output logic [ADDR_W-1:0]         o_rd_addr,
    input  logic [DATA_W-1:0]         i_rd_data,
    input  logic                      i_rd_done,
    output logic                      o_wr_req,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [DATA_W-1:0]         o_wr_data,
    input  logic                      i_wr_done,
    output logic [CHANNELS*PTR_W-1:0] o_head,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [15:0]               o_drop_cnt
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    state_t             state, nextState;
    logic [CH_W-1:0]    curCh;
    logic [DATA_W-1:0]  snap;
    logic [DATA_W-1:0]  rdCapture;
    logic               modeReg;
    logic [PTR_W-1:0]   k;
    logic [PTR_W-1:0]   heads [CHANNELS];
    logic               anyPending;
    logic               pickClr;
    logic [CH_W-1:0]    pickCh;
    logic [DATA_W-1:0]  pickData;

    function automatic logic [ADDR_W-1:0] addrOf(input logic [CH_W-1:0] c, input logic [PTR_W-1:0] idx);
        return ADDR_W'(entry_addr(32'(BASE_ADDR), 32'(CH_STRIDE), 32'(c), 32'(idx)));
    endfunction

    photon_hist_pending #(
        .DATA_W  (DATA_W),
        .CHANNELS(CHANNELS),
        .CH_W    (CH_W)
    ) u_pending (
        .clk        (clk),
        .rst        (rst),
        .sampleValid(i_sample_valid),
        .sampleCh   (i_sample_ch),
        .sampleData (i_sample_data),
        .pickClr    (pickClr),
        .anyPending (anyPending),
        .pickCh     (pickCh),
        .pickData   (pickData),
        .dropCnt    (o_drop_cnt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; transfers advance only on a done seen while the request is up.
    always_comb begin
        nextState = state;
        pickClr   = 1'b0;
        o_busy    = (state != IDLE);
        o_done    = 1'b0;
        case (state)
            IDLE:       if (en && anyPending) nextState = PICK;
            PICK: begin
                pickClr   = 1'b1;
                nextState = (i_mode == MODE_RING) ? RING_WR : RD_REQ;
            end
            RD_REQ:     if (o_rd_req && i_rd_done) nextState = WR_REQ;
            WR_REQ:     if (o_wr_req && i_wr_done) nextState = SHIFT_NEXT;
            SHIFT_NEXT: nextState = (k == LAST_IDX) ? TAIL_WR : RD_REQ;
            TAIL_WR:    if (o_wr_req && i_wr_done) nextState = FINISH;
            RING_WR:    if (o_wr_req && i_wr_done) nextState = FINISH;
            FINISH: begin
                o_done    = 1'b1;
                nextState = IDLE;
            end
            default:    nextState = IDLE;
        endcase
    end

    // Request/address/data registers, snapshot, shift index and ring heads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_req  <= 1'b0;
            o_rd_addr <= '0;
            o_wr_req  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            curCh     <= '0;
            snap      <= '0;
            rdCapture <= '0;
            modeReg   <= MODE_SHIFT;
            k         <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                heads[c] <= '0;
            end
        end else begin
            case (state)
                PICK: begin
                    curCh   <= pickCh;
                    snap    <= pickData;
                    modeReg <= i_mode;
                    k       <= PTR_W'(1);
                    if (i_mode == MODE_RING) begin
                        o_wr_req  <= 1'b1;
                        o_wr_addr <= addrOf(pickCh, heads[pickCh]);
                        o_wr_data <= pickData;
                    end else begin
                        o_rd_req  <= 1'b1;
                        o_rd_addr <= addrOf(pickCh, PTR_W'(1));
                    end
                end
                RD_REQ: begin
                    if (o_rd_req && i_rd_done) begin
                        o_rd_req  <= 1'b0;
                        rdCapture <= i_rd_data;
                    end
                end
                WR_REQ: begin
                    // Raised one cycle after the read completes so requests never touch.
                    if (o_wr_req) begin
                        if (i_wr_done) o_wr_req <= 1'b0;
                    end else begin
                        o_wr_req  <= 1'b1;
                        o_wr_addr <= addrOf(curCh, k - 1'b1);
                        o_wr_data <= rdCapture;
                    end
                end
                SHIFT_NEXT: begin
                    if (k == LAST_IDX) begin
                        o_wr_req  <= 1'b1;
                        o_wr_addr <= addrOf(curCh, LAST_IDX);
                        o_wr_data <= snap;
                    end else begin
                        k         <= k + 1'b1;
                        o_rd_req  <= 1'b1;
                        o_rd_addr <= addrOf(curCh, k + 1'b1);
                    end
                end
                TAIL_WR: begin
                    if (o_wr_req && i_wr_done) o_wr_req <= 1'b0;
                end
                RING_WR: begin
                    if (o_wr_req && i_wr_done) begin
                        o_wr_req     <= 1'b0;
                        heads[curCh] <= (heads[curCh] == LAST_IDX) ? '0 : heads[curCh] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_head
        assign o_head[g*PTR_W +: PTR_W] = (modeReg == MODE_RING) ? heads[g] : '0;
    end

endmodule

// File: tb/tb_photon_history_ring.sv
// tb/tb_photon_history_ring.sv - scoreboard bench for photon_history_ring (DEPTH=4, CHANNELS=2)
module tb_photon_history_ring;

    localparam int BASE   = 384000;
    localparam int STRIDE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        i_mode = 1'b0;
    logic        i_sample_valid = 1'b0;
    logic        i_sample_ch = 1'b0;
    logic [15:0] i_sample_data = '0;
    logic        o_rd_req;
    logic [23:0] o_rd_addr;
    logic [15:0] i_rd_data = '0;
    logic        i_rd_done = 1'b0;
    logic        o_wr_req;
    logic [23:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        i_wr_done = 1'b0;
    logic [3:0]  o_head;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;
    int doneTotal = 0;
    int bothCnt = 0;
    int unstableCnt = 0;

    logic [15:0] mem [0:2047];
    logic [23:0] expWrAddr[$];
    logic [15:0] expWrData[$];
    logic [23:0] obsWrAddr[$];
    logic [15:0] obsWrData[$];
    logic [23:0] expRdAddr[$];
    logic [23:0] obsRdAddr[$];

    photon_history_ring #(
        .DATA_W(16), .ADDR_W(24), .DEPTH(4), .CHANNELS(2), .BASE_ADDR(BASE), .CH_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .i_mode(i_mode),
        .i_sample_valid(i_sample_valid), .i_sample_ch(i_sample_ch), .i_sample_data(i_sample_data),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_rd_done(i_rd_done),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .i_wr_done(i_wr_done),
        .o_head(o_head), .o_busy(o_busy), .o_done(o_done), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    // SDRAM model: done is raised in the second cycle of a request.
    int rdCnt = 0;
    int wrCnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            i_rd_done = 1'b0; i_wr_done = 1'b0; rdCnt = 0; wrCnt = 0;
        end else begin
            if (o_rd_req && !i_rd_done) begin
                if (rdCnt == 1) begin
                    i_rd_done = 1'b1;
                    i_rd_data = mem[int'(o_rd_addr) - BASE];
                    obsRdAddr.push_back(o_rd_addr);
                end else rdCnt++;
            end else begin
                i_rd_done = 1'b0; rdCnt = 0;
            end
            if (o_wr_req && !i_wr_done) begin
                if (wrCnt == 1) begin
                    i_wr_done = 1'b1;
                    mem[int'(o_wr_addr) - BASE] = o_wr_data;
                    obsWrAddr.push_back(o_wr_addr);
                    obsWrData.push_back(o_wr_data);
                end else wrCnt++;
            end else begin
                i_wr_done = 1'b0; wrCnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && o_done) doneTotal++;
    end

    logic        prevRd = 1'b0, prevWr = 1'b0;
    logic [23:0] prevRdAddr, prevWrAddr;
    logic [15:0] prevWrData;
    always @(negedge clk) begin
        if (!rst) begin
            if (o_rd_req && o_wr_req) bothCnt++;
            if (prevRd && o_rd_req && o_rd_addr !== prevRdAddr) unstableCnt++;
            if (prevWr && o_wr_req && (o_wr_addr !== prevWrAddr || o_wr_data !== prevWrData)) unstableCnt++;
        end
        prevRd = o_rd_req; prevRdAddr = o_rd_addr;
        prevWr = o_wr_req; prevWrAddr = o_wr_addr; prevWrData = o_wr_data;
    end

    task automatic send_sample(input int ch, input int data);
        @(negedge clk);
        i_sample_valid = 1'b1;
        i_sample_ch    = 1'(ch);
        i_sample_data  = 16'(data);
        @(negedge clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic push_wr(input int addr, input int data);
        expWrAddr.push_back(24'(addr));
        expWrData.push_back(16'(data));
    endtask

    task automatic wait_done_total(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (doneTotal >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_rd_req, o_wr_req, o_busy, o_done} !== 4'b0) begin
            errors++; $display("FAIL reset_flags actual %b required 0000", {o_rd_req, o_wr_req, o_busy, o_done});
        end
        checks++;
        if (o_head !== 4'h0 || o_drop_cnt !== 16'h0 || o_rd_addr !== 24'h0 || o_wr_addr !== 24'h0) begin
            errors++; $display("FAIL reset_values head %h drop %h rdaddr %h wraddr %h required all 0", o_head, o_drop_cnt, o_rd_addr, o_wr_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ring();
        int wrAt, doneAt, startDone;
        logic busy6;
        logic [23:0] ea, oa;
        logic [15:0] ed, od;
        i_mode = 1'b1; en = 1'b1;
        startDone = doneTotal;
        for (int i = 0; i < 5; i++) begin
            push_wr(BASE + (i % 4), 10 + i);
            @(negedge clk);
            i_sample_valid = 1'b1; i_sample_ch = 1'b0; i_sample_data = 16'(10 + i);
            wrAt = 0; doneAt = 0; busy6 = 1'b1;
            for (int n = 1; n <= 12; n++) begin
                @(negedge clk);
                i_sample_valid = 1'b0;
                if (o_wr_req && wrAt == 0) wrAt = n;
                if (o_done && doneAt == 0) doneAt = n;
                if (n == 6) busy6 = o_busy;
            end
            if (i == 0) begin
                checks++;
                if (wrAt != 3 || doneAt != 5 || busy6 !== 1'b0) begin
                    errors++; $display("FAIL ring_latency wr_req cycle %0d done cycle %0d busy@6 %b required 3 5 0", wrAt, doneAt, busy6);
                end
            end
            checks++;
            if (o_head[1:0] !== 2'((i + 1) % 4) || doneAt == 0) begin
                errors++; $display("FAIL ring_head[%0d] actual %0d (done at %0d) required %0d", i, o_head[1:0], doneAt, (i + 1) % 4);
            end
        end
        checks++;
        if (doneTotal - startDone != 5) begin
            errors++; $display("FAIL ring_done_pulses actual %0d required 5", doneTotal - startDone);
        end
        while (expWrAddr.size() > 0) begin
            ea = expWrAddr.pop_front(); ed = expWrData.pop_front(); checks++;
            if (obsWrAddr.size() == 0) begin
                errors++; $display("FAIL ring_write actual none required %0d/%0d", ea, ed);
            end else begin
                oa = obsWrAddr.pop_front(); od = obsWrData.pop_front();
                if (oa !== ea || od !== ed) begin
                    errors++; $display("FAIL ring_write actual %0d/%0d required %0d/%0d", oa, od, ea, ed);
                end
            end
        end
    endtask

    task automatic test_shift();
        bit ok;
        logic [23:0] ea, oa;
        logic [15:0] ed, od;
        logic [15:0] finalExp [4];
        finalExp[0] = 16'd2; finalExp[1] = 16'd3; finalExp[2] = 16'd4; finalExp[3] = 16'd9;
        for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
        i_mode = 1'b0;
        for (int i = 1; i < 4; i++) expRdAddr.push_back(24'(BASE + i));
        push_wr(BASE + 0, 2); push_wr(BASE + 1, 3); push_wr(BASE + 2, 4); push_wr(BASE + 3, 9);
        send_sample(0, 9);
        wait_done_total(doneTotal + 1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL shift_timeout actual no done required done"); end
        while (expRdAddr.size() > 0) begin
            ea = expRdAddr.pop_front(); checks++;
            oa = (obsRdAddr.size() > 0) ? obsRdAddr.pop_front() : 24'hFFFFFF;
            if (oa !== ea) begin errors++; $display("FAIL shift_read actual %0d required %0d", oa, ea); end
        end
        while (expWrAddr.size() > 0) begin
            ea = expWrAddr.pop_front(); ed = expWrData.pop_front(); checks++;
            if (obsWrAddr.size() == 0) begin
                errors++; $display("FAIL shift_write actual none required %0d/%0d", ea, ed);
            end else begin
                oa = obsWrAddr.pop_front(); od = obsWrData.pop_front();
                if (oa !== ea || od !== ed) begin
                    errors++; $display("FAIL shift_write actual %0d/%0d required %0d/%0d", oa, od, ea, ed);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== finalExp[i]) begin
                errors++; $display("FAIL shift_mem[%0d] actual %0d required %0d", i, mem[i], finalExp[i]);
            end
        end
        checks++;
        if (o_head !== 4'h0) begin errors++; $display("FAIL shift_head actual %h required 0", o_head); end
    endtask

    task automatic test_overflow();
        bit ok;
        bit sawBusy;
        int target;
        logic [23:0] ea, oa;
        logic [15:0] ed, od;
        i_mode = 1'b1;
        target = doneTotal + 2;
        push_wr(BASE + 1, 20); push_wr(BASE + STRIDE + 0, 6);
        send_sample(0, 20);
        sawBusy = 1'b0;
        for (int n = 0; n < 10 && !sawBusy; n++) begin
            @(negedge clk);
            sawBusy = o_busy;
        end
        checks++;
        if (!sawBusy) begin errors++; $display("FAIL overflow_busy actual 0 required 1"); end
        send_sample(1, 5);
        send_sample(1, 6);
        wait_done_total(target, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overflow_timeout actual %0d dones required %0d", doneTotal, target); end
        checks++;
        if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL overflow_drop actual %0d required 1", o_drop_cnt); end
        while (expWrAddr.size() > 0) begin
            ea = expWrAddr.pop_front(); ed = expWrData.pop_front(); checks++;
            if (obsWrAddr.size() == 0) begin
                errors++; $display("FAIL overflow_write actual none required %0d/%0d", ea, ed);
            end else begin
                oa = obsWrAddr.pop_front(); od = obsWrData.pop_front();
                if (oa !== ea || od !== ed) begin
                    errors++; $display("FAIL overflow_write actual %0d/%0d required %0d/%0d", oa, od, ea, ed);
                end
            end
        end
    endtask

    task automatic test_en_round_robin();
        bit ok;
        bit activity;
        logic [23:0] ea, oa;
        logic [15:0] ed, od;
        i_mode = 1'b1; en = 1'b1;
        push_wr(BASE + 2, 29);
        send_sample(0, 29);
        wait_done_total(doneTotal + 1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_warmup_timeout actual no done required done"); end
        en = 1'b0;
        send_sample(0, 30);
        send_sample(1, 31);
        activity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_busy || o_rd_req || o_wr_req) activity = 1'b1;
        end
        checks++;
        if (activity) begin errors++; $display("FAIL en_gate actual activity required idle"); end
        push_wr(BASE + STRIDE + 1, 31); push_wr(BASE + 3, 30);
        en = 1'b1;
        wait_done_total(doneTotal + 2, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout actual %0d dones required 2 more", doneTotal); end
        while (expWrAddr.size() > 0) begin
            ea = expWrAddr.pop_front(); ed = expWrData.pop_front(); checks++;
            if (obsWrAddr.size() == 0) begin
                errors++; $display("FAIL rr_write actual none required %0d/%0d", ea, ed);
            end else begin
                oa = obsWrAddr.pop_front(); od = obsWrData.pop_front();
                if (oa !== ea || od !== ed) begin
                    errors++; $display("FAIL rr_write actual %0d/%0d required %0d/%0d", oa, od, ea, ed);
                end
            end
        end
        checks++;
        if (o_head !== 4'b1000 || o_drop_cnt !== 16'd1) begin
            errors++; $display("FAIL rr_heads actual head %b drop %0d required 1000 1", o_head, o_drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit sawRd;
        logic [23:0] ea, oa;
        logic [15:0] ed, od;
        i_mode = 1'b0; en = 1'b1;
        send_sample(0, 50);
        sawRd = 1'b0;
        for (int n = 0; n < 20 && !sawRd; n++) begin
            @(negedge clk);
            sawRd = o_rd_req;
        end
        checks++;
        if (!sawRd) begin errors++; $display("FAIL midreset_rdreq actual 0 required 1"); end
        rst = 1'b1;
        #1;
        checks++;
        if (o_rd_req !== 1'b0 || o_busy !== 1'b0 || o_drop_cnt !== 16'd0) begin
            errors++; $display("FAIL midreset_outputs rd_req %b busy %b drop %0d required 0 0 0", o_rd_req, o_busy, o_drop_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obsRdAddr.delete(); obsWrAddr.delete(); obsWrData.delete();
        repeat (5) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_flags busy actual %b required 0", o_busy); end
        i_mode = 1'b1;
        push_wr(BASE + 0, 77);
        send_sample(0, 77);
        wait_done_total(doneTotal + 1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_timeout actual no done required done"); end
        while (expWrAddr.size() > 0) begin
            ea = expWrAddr.pop_front(); ed = expWrData.pop_front(); checks++;
            if (obsWrAddr.size() == 0) begin
                errors++; $display("FAIL midreset_write actual none required %0d/%0d", ea, ed);
            end else begin
                oa = obsWrAddr.pop_front(); od = obsWrData.pop_front();
                if (oa !== ea || od !== ed) begin
                    errors++; $display("FAIL midreset_write actual %0d/%0d required %0d/%0d", oa, od, ea, ed);
                end
            end
        end
        checks++;
        if (o_head !== 4'b0001) begin errors++; $display("FAIL midreset_heads actual %b required 0001", o_head); end
    endtask

    task automatic test_protocol();
        checks++;
        if (bothCnt != 0) begin errors++; $display("FAIL rd_wr_overlap actual %0d required 0", bothCnt); end
        checks++;
        if (unstableCnt != 0) begin errors++; $display("FAIL req_stability actual %0d required 0", unstableCnt); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        test_reset();
        test_ring();
        test_shift();
        test_overflow();
        test_en_round_robin();
        test_reset_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
